// File: rtl/dcache_arbiter_pkg.sv
// Shared data-cache arbiter definitions: micro-op encodings and the arbiter FSM states.
package Utilities;

   localparam logic [4:0] NOP = 5'b00000;
   localparam logic [4:0] LDR = 5'b00011;
   localparam logic [4:0] STR = 5'b00100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

   function automatic logic [4:0] mem_uop(input logic we);
      return we ? STR : LDR;
   endfunction

endpackage

// File: rtl/dcache_arbiter_if.sv
// Two-requester data-cache bus: requester handshakes plus the arbiter-to-cache port.
interface dcache_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p1_req;
   logic              p0_we;
   logic              p1_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p1_wdata;
   logic              p0_ack;
   logic              p1_ack;
   logic [DATA_W-1:0] p0_rdata;
   logic [DATA_W-1:0] p1_rdata;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_data_in;
   logic [4:0]        dc_uop;
   logic [DATA_W-1:0] dc_data_out;
   logic              busy;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, dc_data_out,
      output p0_ack, p1_ack, p0_rdata, p1_rdata, dc_addr, dc_data_in, dc_uop, busy
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, dc_data_out,
      input  p0_ack, p1_ack, p0_rdata, p1_rdata, dc_addr, dc_data_in, dc_uop, busy
   );
endinterface

// File: rtl/dcache_arbiter_pick.sv
// Grant selection for two requesters. DCACHE_ARB_RR_EN selects round-robin
// (i_ptr = 1 gives p1 the tie); otherwise p0 has fixed priority and i_ptr is ignored.
module dcache_arb_pick (
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_ptr,
   output logic [1:0] o_gnt
);
`ifdef DCACHE_ARB_RR_EN
   // Tie goes to the side the pointer favours; a lone request always wins
   always_comb begin
      o_gnt = 2'b00;
      if (i_req0 && i_req1) begin
         o_gnt = i_ptr ? 2'b10 : 2'b01;
      end else begin
         o_gnt = {i_req1, i_req0};
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = i_ptr;

   // Fixed priority: p0 first
   always_comb begin
      o_gnt = 2'b00;
      if (i_req0) begin
         o_gnt = 2'b01;
      end else if (i_req1) begin
         o_gnt = 2'b10;
      end else begin
         o_gnt = 2'b00;
      end
   end
`endif
endmodule

// File: rtl/dcache_arbiter.sv
// Arbitrates a pipeline (p0) and a debug loader (p1) onto one data-cache port with
// an IDLE -> ISSUE -> RESP sequence. Build option DCACHE_ARB_RR_EN (see dcache_arb_pick).
module dcache_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input logic             clock,
   input logic             reset,
   dcache_arbiter_if.slave bus
);
   import Utilities::*;

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [1:0]        r_gnt;
   logic              r_ptr;
   logic [1:0]        w_gnt;
   logic [4:0]        w_uop;
   logic              w_ack0;
   logic              w_ack1;

   dcache_arb_pick u_pick (
      .i_req0 (bus.p0_req),
      .i_req1 (bus.p1_req),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt)
   );

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Capture the winner's operands in IDLE; the pointer hands the next tie to the other side
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr  <= {ADDR_W{1'b0}};
         r_wdata <= {DATA_W{1'b0}};
         r_we    <= 1'b0;
         r_gnt   <= 2'b00;
         r_ptr   <= 1'b0;
      end else if ((r_state == ST_IDLE) && (w_gnt != 2'b00)) begin
         r_gnt <= w_gnt;
         r_ptr <= w_gnt[0];
         if (w_gnt[1]) begin
            r_addr  <= bus.p1_addr;
            r_wdata <= bus.p1_wdata;
            r_we    <= bus.p1_we;
         end else begin
            r_addr  <= bus.p0_addr;
            r_wdata <= bus.p0_wdata;
            r_we    <= bus.p0_we;
         end
      end
   end

   // Next state and cache micro-op
   always_comb begin
      w_next = r_state;
      w_uop  = NOP;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt != 2'b00) begin
               w_next = ST_ISSUE;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_next = ST_RESP;
            w_uop  = mem_uop(r_we);
         end
         ST_RESP: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign w_ack0 = (r_state == ST_RESP) && r_gnt[0];
   assign w_ack1 = (r_state == ST_RESP) && r_gnt[1];

   // The cache read port is already registered, so RESP forwards it directly
   assign bus.p0_ack     = w_ack0;
   assign bus.p1_ack     = w_ack1;
   assign bus.p0_rdata   = (w_ack0 && !r_we) ? bus.dc_data_out : {DATA_W{1'b0}};
   assign bus.p1_rdata   = (w_ack1 && !r_we) ? bus.dc_data_out : {DATA_W{1'b0}};
   assign bus.dc_addr    = r_addr;
   assign bus.dc_data_in = r_wdata;
   assign bus.dc_uop     = w_uop;
   assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter: directed scenarios plus random two-port traffic
// against a transaction-level model (3 cycles per access, ack on the third).
module tb_dcache_arbiter;
   import Utilities::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] cache_mem [32] = '{default: 32'd0};
   logic [31:0] cache_q = 32'd0;
   logic [31:0] ref_mem [32] = '{default: 32'd0};
   logic        m_prio1 = 1'b0;

   logic        pend [2];
   logic        twe [2];
   logic [4:0]  taddr [2];
   logic [31:0] twd [2];

   dcache_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   dcache_arbiter #(.ADDR_W(5), .DATA_W(32)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Data-cache model: stores commit on the falling edge, loads are registered
   always @(negedge clock) if (bus.dc_uop == STR) cache_mem[bus.dc_addr] <= bus.dc_data_in;
   always @(posedge clock) if (bus.dc_uop == LDR) cache_q <= cache_mem[bus.dc_addr];
   assign bus.dc_data_out = cache_q;

   function automatic int pick_model(input logic r0, input logic r1);
`ifdef DCACHE_ARB_RR_EN
      if (r0 && r1) return m_prio1 ? 1 : 0;
`endif
      return r0 ? 0 : 1;
   endfunction

   task automatic drive();
      bus.p0_req   = pend[0];  bus.p1_req   = pend[1];
      bus.p0_we    = twe[0];   bus.p1_we    = twe[1];
      bus.p0_addr  = taddr[0]; bus.p1_addr  = taddr[1];
      bus.p0_wdata = twd[0];   bus.p1_wdata = twd[1];
   endtask

   // Single-port access; entered and left just after a rising edge
   task automatic do_txn(input int p, input logic we, input logic [4:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
      logic got = 1'b0;
      pend[p] = 1'b1; twe[p] = we; taddr[p] = a; twd[p] = d;
      drive();
      rd = 32'd0; lat = -1;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clock);
         if ((p == 0) ? bus.p0_ack : bus.p1_ack) begin
            got = 1'b1; lat = i;
            rd = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
         end
      end
      @(posedge clock); #1;
      pend[p] = 1'b0;
      drive();
      if (got) begin
         if (we) ref_mem[a] = d;
         m_prio1 = (p == 0);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack, bus.p0_rdata, bus.p1_rdata,
           bus.dc_addr, bus.dc_data_in} !== 109'd0) begin
         n_errors++;
         $display("FAIL reset_state got busy=%b uop=%h ack=%b%b addr=%h din=%h want all zero",
                  bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack, bus.dc_addr, bus.dc_data_in);
      end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      int lat;
      do_txn(0, 1'b1, 5'd3, 32'hDEADBEEF, rd, lat);
      n_checks++;
      if (lat !== 3) begin n_errors++; $display("FAIL store_latency got %0d want 3", lat); end
      do_txn(0, 1'b0, 5'd3, 32'd0, rd, lat);
      n_checks++;
      if (lat !== 3 || rd !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL load_back got lat=%0d data=%h want lat=3 data=deadbeef", lat, rd);
      end
   endtask

   task automatic test_tie();
      int t[2] = '{0, 0};
      int first;
      first = pick_model(1'b1, 1'b1);
      pend[0] = 1'b1; twe[0] = 1'b0; taddr[0] = 5'd3;
      pend[1] = 1'b1; twe[1] = 1'b0; taddr[1] = 5'd9;
      drive();
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (bus.p0_ack && t[0] == 0) begin
            t[0] = c; m_prio1 = 1'b1;
            n_checks++;
            if (bus.p0_rdata !== ref_mem[3]) begin
               n_errors++; $display("FAIL tie_p0_data got %h want %h", bus.p0_rdata, ref_mem[3]);
            end
         end
         if (bus.p1_ack && t[1] == 0) begin
            t[1] = c; m_prio1 = 1'b0;
            n_checks++;
            if (bus.p1_rdata !== ref_mem[9]) begin
               n_errors++; $display("FAIL tie_p1_data got %h want %h", bus.p1_rdata, ref_mem[9]);
            end
         end
         @(posedge clock); #1;
         if (t[0] != 0) pend[0] = 1'b0;
         if (t[1] != 0) pend[1] = 1'b0;
         drive();
      end
      n_checks++;
      if (t[first] !== 3 || t[1 - first] !== 6) begin
         n_errors++;
         $display("FAIL tie_order got p0@%0d p1@%0d want winner p%0d@3 other@6", t[0], t[1], first);
      end
   endtask

   task automatic test_starve();
      int w = 0;
      logic [1:0] exp_ack;
      pend[0] = 1'b1; twe[0] = 1'b0; taddr[0] = 5'd1;
      pend[1] = 1'b1; twe[1] = 1'b0; taddr[1] = 5'd2;
      drive();
      for (int c = 1; c <= 12; c++) begin
         if (c % 3 == 1) begin
            w = pick_model(1'b1, 1'b1);
            m_prio1 = (w == 0);
         end
         exp_ack = (c % 3 == 0) ? ((w == 0) ? 2'b01 : 2'b10) : 2'b00;
         @(negedge clock);
         n_checks++;
         if ({bus.p1_ack, bus.p0_ack} !== exp_ack) begin
            n_errors++;
            $display("FAIL starve_cycle%0d got ack=%b%b want p1p0=%b", c, bus.p1_ack, bus.p0_ack, exp_ack);
         end
         @(posedge clock); #1;
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive();
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int lat;
      pend[1] = 1'b1; twe[1] = 1'b1; taddr[1] = 5'd7; twd[1] = 32'h12345678;
      drive();
      @(posedge clock); #1;
      n_checks++;
      if (bus.dc_uop !== STR) begin
         n_errors++; $display("FAIL abort_issue got uop=%h want %h", bus.dc_uop, STR);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.dc_uop, bus.dc_addr, bus.p1_ack} !== 12'd0) begin
         n_errors++;
         $display("FAIL abort_async got busy=%b uop=%h addr=%h want 0", bus.busy, bus.dc_uop, bus.dc_addr);
      end
      pend[1] = 1'b0;
      drive();
      m_prio1 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin
         n_errors++; $display("FAIL abort_ack got %b%b want 00", bus.p0_ack, bus.p1_ack);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      do_txn(1, 1'b0, 5'd7, 32'd0, rd, lat);
      n_checks++;
      if (lat !== 3 || rd !== 32'd0) begin
         n_errors++; $display("FAIL abort_reload got lat=%0d data=%h want lat=3 data=0", lat, rd);
      end
   endtask

   task automatic test_random();
      int done = 0;
      int w;
      logic [31:0] exp_rd;
      for (int it = 0; it < 20000 && done < 1000; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(1, 0) == 1) begin
               pend[p] = 1'b1; twe[p] = 1'($urandom_range(1, 0));
               taddr[p] = 5'($urandom_range(31, 0)); twd[p] = $urandom();
            end
         end
         drive();
         if (!pend[0] && !pend[1]) begin
            @(negedge clock);
            n_checks++;
            if ({bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack} !== 8'd0) begin
               n_errors++;
               $display("FAIL rnd_idle got busy=%b uop=%h ack=%b%b want 0", bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack);
            end
            @(posedge clock); #1;
         end else begin
            w = pick_model(pend[0], pend[1]);
            m_prio1 = (w == 0);
            @(negedge clock);
            n_checks++;
            if ({bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack} !== 8'd0) begin
               n_errors++;
               $display("FAIL rnd_sample got busy=%b uop=%h ack=%b%b want 0", bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack);
            end
            @(posedge clock); #1;
            @(negedge clock);
            n_checks++;
            if ({bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack} !== {1'b1, (twe[w] ? STR : LDR), 2'b00}) begin
               n_errors++;
               $display("FAIL rnd_issue got busy=%b uop=%h ack=%b%b want busy=1 we=%b", bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack, twe[w]);
            end
            n_checks++;
            if (bus.dc_addr !== taddr[w] || (twe[w] && bus.dc_data_in !== twd[w])) begin
               n_errors++;
               $display("FAIL rnd_bus got addr=%h din=%h want addr=%h din=%h", bus.dc_addr, bus.dc_data_in, taddr[w], twd[w]);
            end
            @(posedge clock); #1;
            exp_rd = twe[w] ? 32'd0 : ref_mem[taddr[w]];
            @(negedge clock);
            n_checks++;
            if ({bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack} !== {1'b1, NOP, (w == 0), (w == 1)}) begin
               n_errors++;
               $display("FAIL rnd_resp got busy=%b uop=%h ack=%b%b want winner p%0d", bus.busy, bus.dc_uop, bus.p0_ack, bus.p1_ack, w);
            end
            n_checks++;
            if ({bus.p0_rdata, bus.p1_rdata} !== {((w == 0) ? exp_rd : 32'd0), ((w == 1) ? exp_rd : 32'd0)}) begin
               n_errors++;
               $display("FAIL rnd_rdata got p0=%h p1=%h want p%0d=%h", bus.p0_rdata, bus.p1_rdata, w, exp_rd);
            end
            @(posedge clock); #1;
            if (twe[w]) ref_mem[taddr[w]] = twd[w];
            pend[w] = 1'b0;
            done++;
         end
      end
      n_checks++;
      if (done !== 1000) begin n_errors++; $display("FAIL rnd_count got %0d want 1000", done); end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; twe[p] = 1'b0; taddr[p] = 5'd0; twd[p] = 32'd0;
      end
      drive();
      test_reset();
      test_store_load();
      test_tie();
      test_starve();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
